// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl_pkg
//  Description : Shared opcodes, instruction field positions and FSM states
//                for the ALU issue sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_issue_ctrl_pkg;

    // ALU opcodes: register forms
    localparam logic [7:0] ALU_NOP    = 8'h00;
    localparam logic [7:0] ALU_ADD    = 8'h01;
    localparam logic [7:0] ALU_SUB    = 8'h02;
    localparam logic [7:0] ALU_IADD   = 8'h03;  // saturating signed add
    localparam logic [7:0] ALU_AND    = 8'h04;
    localparam logic [7:0] ALU_OR     = 8'h05;
    localparam logic [7:0] ALU_XOR    = 8'h06;
    localparam logic [7:0] ALU_SHL    = 8'h07;
    localparam logic [7:0] ALU_SHR    = 8'h08;
    localparam logic [7:0] ALU_MAC    = 8'h09;
    // ALU opcodes: immediate forms (A = imm16, B = reg[ra], C = 0)
    localparam logic [7:0] ALU_ADD_I  = 8'h11;
    localparam logic [7:0] ALU_SUB_I  = 8'h12;
    localparam logic [7:0] ALU_IADD_I = 8'h13;
    localparam logic [7:0] ALU_AND_I  = 8'h14;
    localparam logic [7:0] ALU_OR_I   = 8'h15;
    localparam logic [7:0] ALU_XOR_I  = 8'h16;
    // Sequencer-local opcodes
    localparam logic [7:0] OP_BEZ     = 8'h20;
    localparam logic [7:0] OP_BNEZ    = 8'h21;
    localparam logic [7:0] OP_HALT    = 8'hFF;

    // Instruction field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 24;
    localparam int RD_HI  = 23;
    localparam int RD_LO  = 20;
    localparam int RA_HI  = 19;
    localparam int RA_LO  = 16;
    localparam int RB_HI  = 15;
    localparam int RB_LO  = 12;
    localparam int RC_HI  = 11;
    localparam int RC_LO  = 8;
    localparam int SH_HI  = 4;
    localparam int SH_LO  = 0;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    function automatic logic is_imm_op(input logic [7:0] op);
        return (op == ALU_ADD_I) || (op == ALU_SUB_I) || (op == ALU_IADD_I) ||
               (op == ALU_AND_I) || (op == ALU_OR_I)  || (op == ALU_XOR_I);
    endfunction

    function automatic logic is_branch_op(input logic [7:0] op);
        return (op == OP_BEZ) || (op == OP_BNEZ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : issue_regfile
//  Description : 16xN register file, three read ports (A/B/C), one write
//                port, debug read port, r0 hardwired to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module issue_regfile #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   raddr_a,
    input  logic [3:0]   raddr_b,
    input  logic [3:0]   raddr_c,
    output logic [N-1:0] rdata_a,
    output logic [N-1:0] rdata_b,
    output logic [N-1:0] rdata_c,
    input  logic         we,
    input  logic [3:0]   waddr,
    input  logic [N-1:0] wdata,
    input  logic [3:0]   dbg_raddr,
    output logic [N-1:0] dbg_rdata
);

    logic [N-1:0] r_mem [16];

    // Storage: cleared on reset, writes to r0 dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && (waddr != 4'd0)) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata_a   = (raddr_a   == 4'd0) ? '0 : r_mem[raddr_a];
    assign rdata_b   = (raddr_b   == 4'd0) ? '0 : r_mem[raddr_b];
    assign rdata_c   = (raddr_c   == 4'd0) ? '0 : r_mem[raddr_c];
    assign dbg_rdata = (dbg_raddr == 4'd0) ? '0 : r_mem[dbg_raddr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Fetch/decode/execute/write-back sequencer driving a
//                combinational ALU, with BEZ/BNEZ branches and HALT.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int              N        = 16,
    parameter int              O        = 8,
    parameter int              S        = 5,
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [O-1:0]    alu_opcode,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    output logic [N-1:0]    alu_c,
    output logic [S-1:0]    alu_shift,
    input  logic [N-1:0]    alu_out,
    output logic            busy,
    output logic            done,
    input  logic [3:0]      dbg_raddr,
    output logic [N-1:0]    dbg_rdata
);

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [N-1:0]    r_result;

    logic [7:0]      w_op;
    logic [3:0]      w_rd;
    logic [3:0]      w_ra;
    logic [3:0]      w_rb;
    logic [3:0]      w_rc;
    logic [15:0]     w_imm;
    logic [N-1:0]    w_rdata_a;
    logic [N-1:0]    w_rdata_b;
    logic [N-1:0]    w_rdata_c;
    logic            w_taken;

    assign w_op  = r_instr[OPC_HI:OPC_LO];
    assign w_rd  = r_instr[RD_HI:RD_LO];
    assign w_ra  = r_instr[RA_HI:RA_LO];
    assign w_rb  = r_instr[RB_HI:RB_LO];
    assign w_rc  = r_instr[RC_HI:RC_LO];
    assign w_imm = r_instr[IMM_HI:IMM_LO];

    issue_regfile #(.N(N)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .raddr_a   (w_ra),
        .raddr_b   (w_rb),
        .raddr_c   (w_rc),
        .rdata_a   (w_rdata_a),
        .rdata_b   (w_rdata_b),
        .rdata_c   (w_rdata_c),
        .we        (r_state == ST_WB),
        .waddr     (w_rd),
        .wdata     (r_result),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata)
    );

    assign w_taken = ((w_op == OP_BEZ)  && (w_rdata_a == '0)) ||
                     ((w_op == OP_BNEZ) && (w_rdata_a != '0));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_FETCH;
            ST_FETCH:  if (imem_ack) w_next = ST_DECODE;
            ST_DECODE: begin
                if (w_op == OP_HALT)         w_next = ST_HALTED;
                else if (is_branch_op(w_op)) w_next = ST_FETCH;
                else                         w_next = ST_EXEC;
            end
            ST_EXEC:   w_next = ST_WB;
            ST_WB:     w_next = ST_FETCH;
            ST_HALTED: if (start) w_next = ST_FETCH;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Datapath: PC, instruction latch, ALU operand registers, result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_result   <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_c      <= '0;
            alu_shift  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (start) r_pc <= RESET_PC;
                end
                ST_FETCH: begin
                    if (imem_ack) r_instr <= imem_data;
                end
                ST_DECODE: begin
                    if (is_branch_op(w_op)) begin
                        r_pc <= w_taken ? w_imm[PC_W-1:0] : r_pc + PC_W'(1);
                    end else if (w_op != OP_HALT) begin
                        alu_opcode <= O'(w_op);
                        if (is_imm_op(w_op)) begin
                            alu_a     <= N'(w_imm);
                            alu_b     <= w_rdata_a;
                            alu_c     <= '0;
                            alu_shift <= '0;
                        end else begin
                            alu_a     <= w_rdata_a;
                            alu_b     <= w_rdata_b;
                            alu_c     <= w_rdata_c;
                            alu_shift <= S'(r_instr[SH_HI:SH_LO]);
                        end
                    end
                end
                ST_EXEC: r_result <= alu_out;
                ST_WB:   r_pc     <= r_pc + PC_W'(1);
                default: ;
            endcase
        end
    end

    assign imem_req  = (r_state == ST_FETCH);
    assign imem_addr = r_pc;
    assign busy      = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                       (r_state == ST_EXEC)  || (r_state == ST_WB);
    assign done      = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_ctrl
//  Description : Directed self-checking bench for alu_issue_ctrl with a
//                small ALU model and an instruction memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_c;
    logic [4:0]  alu_shift;
    logic [15:0] alu_out;
    logic        busy;
    logic        done;
    logic [3:0]  dbg_raddr;
    logic [15:0] dbg_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int wait_cycles = 0;
    int waited = 0;
    logic [31:0] mem [1024];

    alu_issue_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_shift  (alu_shift),
        .alu_out    (alu_out),
        .busy       (busy),
        .done       (done),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    always #5 clk = ~clk;

    // ALU model: plain and saturating add, everything else returns 0
    always_comb begin
        logic signed [16:0] sum;
        sum     = $signed({alu_a[15], alu_a}) + $signed({alu_b[15], alu_b});
        alu_out = '0;
        case (alu_opcode)
            ALU_ADD, ALU_ADD_I:   alu_out = alu_a + alu_b;
            ALU_IADD, ALU_IADD_I: begin
                if (sum > 17'sd32767)       alu_out = 16'h7FFF;
                else if (sum < -17'sd32768) alu_out = 16'h8000;
                else                        alu_out = sum[15:0];
            end
            default: alu_out = '0;
        endcase
    end

    // Instruction memory: answers a request after wait_cycles idle cycles
    always @(negedge clk) begin
        if (imem_req) begin
            if (waited >= wait_cycles) begin
                imem_ack  = 1'b1;
                imem_data = mem[imem_addr];
                waited    = 0;
            end else begin
                imem_ack = 1'b0;
                waited++;
            end
        end else begin
            imem_ack = 1'b0;
            waited   = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
        dbg_raddr = a;
        #1;
        chk(tag, {16'h0, dbg_rdata}, {16'h0, exp});
    endtask

    // Wait for the next fresh fetch request and check its address
    task automatic wait_fetch(input string tag, input logic [9:0] exp);
        bit seen_low = 1'b0;
        bit found    = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (!imem_req)     seen_low = 1'b1;
            else if (seen_low) found    = 1'b1;
        end
        if (!found) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else        chk(tag, {22'h0, imem_addr}, {22'h0, exp});
    endtask

    initial begin
        bit          ok;
        int          cnt;
        logic [15:0] a_hold;

        rst       = 1'b1;
        start     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = '0;
        dbg_raddr = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]     = {ALU_ADD_I,  4'd1, 4'd0, 16'h7000};
        mem[1]     = {ALU_IADD_I, 4'd2, 4'd1, 16'h2000};
        mem[2]     = {ALU_ADD_I,  4'd0, 4'd0, 16'h0005};
        mem[3]     = {OP_BEZ,     4'd0, 4'd0, 16'h0010};
        mem[10'h10] = {OP_BNEZ,   4'd0, 4'd0, 16'h0020};
        mem[10'h11] = 32'hFF00_0000;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req",    {31'h0, imem_req}, 32'd0);
        chk("rst_busy",   {31'h0, busy},     32'd0);
        chk("rst_done",   {31'h0, done},     32'd0);
        chk("rst_opcode", {24'h0, alu_opcode}, 32'd0);
        chk("rst_alu_a",  {16'h0, alu_a},    32'd0);
        chk("rst_addr",   {22'h0, imem_addr}, 32'd0);
        chk_reg("rst_r1", 4'd1, 16'h0);

        // First program run
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_req",  {31'h0, imem_req}, 32'd1);
        chk("start_addr", {22'h0, imem_addr}, 32'd0);
        chk("start_busy", {31'h0, busy}, 32'd1);

        wait_fetch("fetch_1", 10'd1);
        repeat (2) @(negedge clk);
        chk("exec_opcode", {24'h0, alu_opcode}, {24'h0, ALU_IADD_I});
        chk("exec_a",      {16'h0, alu_a}, 32'h2000);
        chk("exec_b",      {16'h0, alu_b}, 32'h7000);
        chk("exec_c",      {16'h0, alu_c}, 32'h0);

        wait_fetch("fetch_2", 10'd2);
        chk_reg("r1", 4'd1, 16'h7000);
        chk_reg("r2_sat", 4'd2, 16'h7FFF);

        wait_fetch("fetch_3", 10'd3);
        chk_reg("r0_zero", 4'd0, 16'h0);

        wait_fetch("bez_taken", 10'h010);
        wait_fetch("bnez_not_taken", 10'h011);
        chk_reg("r2_after_br", 4'd2, 16'h7FFF);
        chk_reg("r1_after_br", 4'd1, 16'h7000);

        repeat (2) @(negedge clk);
        chk("halt_done", {31'h0, done},     32'd1);
        chk("halt_busy", {31'h0, busy},     32'd0);
        chk("halt_req",  {31'h0, imem_req}, 32'd0);
        repeat (5) @(negedge clk);
        chk("halt_no_req", {31'h0, imem_req}, 32'd0);

        // Second run: stalled first fetch, then a branch to the top of memory
        mem[3]      = {OP_BEZ,    4'd0, 4'd0, 16'h03FF};
        mem[10'h3FF] = {ALU_ADD_I, 4'd3, 4'd0, 16'h1234};
        wait_cycles = 5;
        a_hold      = alu_a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_req",  {31'h0, imem_req}, 32'd1);
        chk("restart_addr", {22'h0, imem_addr}, 32'd0);
        chk("restart_done", {31'h0, done}, 32'd0);
        cnt = 1;
        ok  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!imem_req) break;
            cnt++;
            if (imem_addr != 10'd0 || alu_a != a_hold || busy != 1'b1) ok = 1'b0;
        end
        wait_cycles = 0;
        chk("stall_req_cycles", cnt, 32'd6);
        chk("stall_stable", {31'h0, ok}, 32'd1);

        wait_fetch("run2_fetch_1", 10'd1);
        wait_fetch("run2_fetch_2", 10'd2);
        wait_fetch("run2_fetch_3", 10'd3);
        wait_fetch("bez_to_top", 10'h3FF);
        wait_fetch("pc_wrap", 10'd0);
        chk_reg("r3", 4'd3, 16'h1234);

        // Reset in the middle of EXEC
        wait_fetch("run2_refetch_1", 10'd1);
        repeat (2) @(negedge clk);
        chk("pre_rst_opcode", {24'h0, alu_opcode}, {24'h0, ALU_IADD_I});
        rst = 1'b1;
        #1;
        chk("mid_rst_req",    {31'h0, imem_req}, 32'd0);
        chk("mid_rst_busy",   {31'h0, busy}, 32'd0);
        chk("mid_rst_opcode", {24'h0, alu_opcode}, 32'd0);
        chk("mid_rst_a",      {16'h0, alu_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reg("post_rst_r1", 4'd1, 16'h0);
        chk("post_rst_addr", {22'h0, imem_addr}, 32'd0);
        chk("post_rst_req",  {31'h0, imem_req}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
